vector_mem_ctrl: RTL and testbench
==================================

// Module: vector_mem_ctrl
// PURPOSE
//   Main-memory controller that sits directly downstream of processing_block.
//   Serves its vector load requests (load_ctrl/load_addr -> load_data) and vector
//   write requests (write_ctrl/write_addr_main/write_data_main) against an internal
//   DEPTH x (CORES*BITS) array, with programmable access latency and a busy/valid
//   handshake the sequencer uses to stall.
// PARAMETERS
//   CORES     32  lanes per vector word
//   BITS      16  bits per lane; word width W = CORES*BITS
//   ADDR_W    10  implemented address bits; DEPTH = 2**ADDR_W
//   READ_LAT   2  cycles spent in RD_WAIT (>=1)
//   WRITE_LAT  1  cycles spent in WR_WAIT (>=1)
// PORTS
//   clock       in   1       rising-edge clock
//   reset       in   1       asynchronous, active-low reset
//   load_ctrl   in   1       load request
//   load_addr   in   16      load word address
//   write_ctrl  in   1       write request
//   write_addr  in   16      write word address
//   write_data  in   W       write vector
//   load_data   out  W       loaded vector; holds until next load completes
//   load_valid  out  1       1-cycle pulse: load_data updated
//   write_done  out  1       1-cycle pulse: write committed
//   busy        out  1       1 in any state other than IDLE
//   req_err     out  1       sticky: load_ctrl & write_ctrl seen together in IDLE
//   parity_err  out  CORES   per-lane parity mismatch (VMEM_PARITY_EN only)
// BEHAVIOUR
//   - Reset (reset==0, async): state=IDLE, counter=0, load_data=0, load_valid=0,
//     write_done=0, req_err=0, parity_err=0. Array contents NOT cleared.
//   - FSM: IDLE, RD_WAIT, WR_WAIT, DONE.
//     IDLE: on edge with write_ctrl=1 -> latch addr/data, cnt=WRITE_LAT-1, WR_WAIT;
//       else load_ctrl=1 -> latch addr, cnt=READ_LAT-1, RD_WAIT. Both high: write
//       wins, req_err<=1 (sticky until reset).
//     RD_WAIT: cnt>0 -> cnt-1; cnt==0 -> load_data<=mem[addr], load_valid<=1, DONE.
//     WR_WAIT: cnt>0 -> cnt-1; cnt==0 -> mem[addr]<=data, write_done<=1, DONE.
//     DONE: one cycle, pulses deassert on exit, -> IDLE.
//   - Latency: load_valid high READ_LAT+1 edges after acceptance edge; busy
//     deasserts same edge DONE->IDLE. Total occupancy READ_LAT+2 / WRITE_LAT+2.
//   - Requests are sampled only in IDLE; ctrl/addr/data changes while busy are
//     ignored. A ctrl still high in the IDLE after DONE issues a new request;
//     requester drops ctrl on load_valid/write_done.
//   - Address: upper 16-ADDR_W bits ignored (wrap modulo DEPTH).
//   - Read-after-write to same address: the later load returns new data (write
//     committed before DONE, so no forwarding needed).
//   - Reset mid-operation: access aborted; pending write NOT committed unless its
//     commit edge already occurred; no pulse emitted.
// CONFIGURATION
//   VMEM_PARITY_EN defined: array stores one even-parity bit per lane, computed
//     on write; on load completion parity_err[i] <= parity mismatch of lane i, held
//     until next load completes; parity_err port present.
//   Not defined: no parity storage, parity_err port absent, no other change.
// TESTING
//   1 Reset: drive reset=0 mid RD_WAIT -> all outputs 0, busy=0 immediately,
//     no load_valid afterwards.
//   2 Write addr 0x0005 data {32{16'h3F80}}, then load 0x0005 -> write_done
//     after 2 edges, load_valid after 3 edges, load_data={32{16'h3F80}}.
//   3 Wrap: write 0x0403 data A, load 0x0003 (ADDR_W=10) -> load_data=A.
//   4 load_ctrl & write_ctrl both high at addr 0x0010 -> write performed,
//     req_err=1 and stays 1 until reset, no load_valid.
//   5 Change load_addr 0x0001->0x0002 while busy -> data from 0x0001 returned;
//     held load_ctrl -> second access starts on the edge after DONE.
//   6 VMEM_PARITY_EN: backdoor-flip bit 0 of lane 3 at addr 7, load 7 ->
//     parity_err=32'h0000_0008; without macro compile passes, port absent.

Source files
------------

// File: rtl/vector_mem_ctrl.sv
// Vector main-memory controller: serves load/write requests against a DEPTH x (CORES*BITS)
// array with programmable latency. Define VMEM_PARITY_EN for per-lane even parity and parity_err.
module vector_mem_ctrl #(
  parameter int CORES     = 32,
  parameter int BITS      = 16,
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_ctrl,
  input  logic [15:0]             load_addr,
  input  logic                    write_ctrl,
  input  logic [15:0]             write_addr,
  input  logic [CORES*BITS-1:0]   write_data,
  output logic [CORES*BITS-1:0]   load_data,
  output logic                    load_valid,
  output logic                    write_done,
  output logic                    busy,
  output logic                    req_err
`ifdef VMEM_PARITY_EN
  ,
  output logic [CORES-1:0]        parity_err
`endif
);

  localparam int W       = CORES * BITS;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [W-1:0]        data_q;
  logic [W-1:0]        mem [DEPTH];
  logic [W-1:0]        rd_word;
  logic                rd_fire, wr_fire;

  // Upper address bits are deliberately dropped so addresses wrap modulo DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{load_addr[15:ADDR_W], write_addr[15:ADDR_W]};

  assign rd_fire = (state == RD_WAIT) && (cnt == '0);
  assign wr_fire = (state == WR_WAIT) && (cnt == '0);
  assign rd_word = mem[addr_q];
  assign busy    = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (write_ctrl)     next_state = WR_WAIT;
        else if (load_ctrl) next_state = RD_WAIT;
      end
      RD_WAIT: if (cnt == '0) next_state = DONE;
      WR_WAIT: if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Array has no reset; reset forces IDLE, so an aborted write never reaches its commit edge.
  always_ff @(posedge clock) begin
    if (wr_fire) mem[addr_q] <= data_q;
  end

`ifdef VMEM_PARITY_EN
  logic [CORES-1:0] par_mem [DEPTH];
  logic [CORES-1:0] wr_par, rd_par_err;

  always_comb begin
    wr_par     = '0;
    rd_par_err = '0;
    for (int i = 0; i < CORES; i++) begin
      wr_par[i]     = ^data_q[i*BITS +: BITS];
      rd_par_err[i] = (^rd_word[i*BITS +: BITS]) ^ par_mem[addr_q][i];
    end
  end

  always_ff @(posedge clock) begin
    if (wr_fire) par_mem[addr_q] <= wr_par;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       parity_err <= '0;
    else if (rd_fire) parity_err <= rd_par_err;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      write_done <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (write_ctrl) begin
            addr_q <= write_addr[ADDR_W-1:0];
            data_q <= write_data;
            cnt    <= CNT_W'(WRITE_LAT - 1);
            if (load_ctrl) req_err <= 1'b1;
          end else if (load_ctrl) begin
            addr_q <= load_addr[ADDR_W-1:0];
            cnt    <= CNT_W'(READ_LAT - 1);
          end
        end
        RD_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            load_data  <= rd_word;
            load_valid <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else           write_done <= 1'b1;
        end
        DONE: begin
          load_valid <= 1'b0;
          write_done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_ctrl.sv
// Directed, table-driven bench for vector_mem_ctrl (default parameters); parity checks
// are compiled in when VMEM_PARITY_EN is defined.
module tb_vector_mem_ctrl;

  localparam int CORES = 32;
  localparam int BITS  = 16;
  localparam int W     = CORES * BITS;

  logic          clock;
  logic          reset;
  logic          load_ctrl;
  logic [15:0]   load_addr;
  logic          write_ctrl;
  logic [15:0]   write_addr;
  logic [W-1:0]  write_data;
  logic [W-1:0]  load_data;
  logic          load_valid;
  logic          write_done;
  logic          busy;
  logic          req_err;
`ifdef VMEM_PARITY_EN
  logic [CORES-1:0] parity_err;
`endif

  vector_mem_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .load_ctrl  (load_ctrl),
    .load_addr  (load_addr),
    .write_ctrl (write_ctrl),
    .write_addr (write_addr),
    .write_data (write_data),
    .load_data  (load_data),
    .load_valid (load_valid),
    .write_done (write_done),
    .busy       (busy),
    .req_err    (req_err)
`ifdef VMEM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit           is_write;
    logic [15:0]  addr;
    logic [W-1:0] data;
  } vec_t;

  vec_t vecs [9];
  int   checks = 0;
  int   passes = 0;

  task automatic checkOutput(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    else passes++;
  endtask

  // Counts edges until the requested pulse appears; 99 means it never came.
  task automatic waitPulse(input bit want_done, output int edges, output bit other_seen);
    bit got;
    got = 0;
    other_seen = 0;
    edges = 0;
    while (!got && edges < 20) begin
      @(posedge clock); #1;
      edges++;
      if (want_done ? write_done : load_valid) got = 1;
      if (want_done ? load_valid : write_done) other_seen = 1;
    end
    if (!got) edges = 99;
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [W-1:0] d, input string nm);
    int e;
    bit o;
    @(negedge clock);
    write_ctrl = 1'b1; write_addr = a; write_data = d;
    waitPulse(1'b1, e, o);
    checkOutput({nm, "_wr_latency"}, W'(e), W'(2));
    @(negedge clock);
    write_ctrl = 1'b0;
    @(posedge clock); #1;
    checkOutput({nm, "_wr_idle"}, W'({busy, write_done}), W'(0));
  endtask

  task automatic doLoad(input logic [15:0] a, input logic [W-1:0] exp, input string nm);
    int e;
    bit o;
    @(negedge clock);
    load_ctrl = 1'b1; load_addr = a;
    waitPulse(1'b0, e, o);
    checkOutput({nm, "_ld_latency"}, W'(e), W'(3));
    checkOutput({nm, "_ld_data"}, load_data, exp);
    @(negedge clock);
    load_ctrl = 1'b0;
    @(posedge clock); #1;
    checkOutput({nm, "_ld_idle"}, W'({busy, load_valid}), W'(0));
    checkOutput({nm, "_ld_hold"}, load_data, exp);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    if (v.is_write) doWrite(v.addr, v.data, nm);
    else            doLoad(v.addr, v.data, nm);
  endtask

  logic [W-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f, pat_1, pat_2;

  initial begin
    int e;
    bit o;
    int seen;

    for (int i = 0; i < CORES; i++) begin
      pat_a[i*BITS +: BITS] = 16'h1000 + 16'(i);
      pat_b[i*BITS +: BITS] = 16'hA5A5 ^ 16'(i);
    end
    pat_c = {16{32'hDEADBEEF}};
    pat_d = {32{16'h0F0F}};
    pat_e = {32{16'h1234}};
    pat_f = {32{16'hFFFF}};
    pat_1 = {32{16'h1111}};
    pat_2 = {32{16'h2222}};

    vecs[0] = '{1'b1, 16'h0005, {32{16'h3F80}}};
    vecs[1] = '{1'b0, 16'h0005, {32{16'h3F80}}};
    vecs[2] = '{1'b1, 16'h0403, pat_a};
    vecs[3] = '{1'b0, 16'h0003, pat_a};
    vecs[4] = '{1'b1, 16'h0003, pat_b};
    vecs[5] = '{1'b0, 16'h0403, pat_b};
    vecs[6] = '{1'b1, 16'h03FF, pat_c};
    vecs[7] = '{1'b0, 16'hFFFF, pat_c};
    vecs[8] = '{1'b0, 16'h0005, {32{16'h3F80}}};

    load_ctrl = 0; write_ctrl = 0; load_addr = 0; write_addr = 0; write_data = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset_flags", W'({busy, load_valid, write_done, req_err}), W'(0));
    checkOutput("reset_load_data", load_data, '0);
`ifdef VMEM_PARITY_EN
    checkOutput("reset_parity_err", W'(parity_err), W'(0));
`endif
    reset = 1'b1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // Simultaneous requests: write wins, req_err is sticky
    @(negedge clock);
    load_ctrl = 1; write_ctrl = 1; load_addr = 16'h0010; write_addr = 16'h0010; write_data = pat_d;
    waitPulse(1'b1, e, o);
    checkOutput("both_wr_latency", W'(e), W'(2));
    checkOutput("both_no_valid", W'(o), W'(0));
    checkOutput("both_req_err", W'(req_err), W'(1));
    @(negedge clock);
    load_ctrl = 0; write_ctrl = 0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("both_req_err_sticky", W'({req_err, load_valid}), W'(2'b10));
    doLoad(16'h0010, pat_d, "both_readback");
    checkOutput("both_req_err_after_load", W'(req_err), W'(1));

    // Address change while busy is ignored; held load_ctrl re-issues after DONE
    doWrite(16'h0001, pat_1, "held_w1");
    doWrite(16'h0002, pat_2, "held_w2");
    @(negedge clock);
    load_ctrl = 1; load_addr = 16'h0001;
    @(posedge clock); #1;
    @(negedge clock);
    load_addr = 16'h0002;
    waitPulse(1'b0, e, o);
    checkOutput("held_first_latency", W'(e), W'(2));
    checkOutput("held_first_data", load_data, pat_1);
    @(posedge clock); #1;
    checkOutput("held_idle_gap", W'(busy), W'(0));
    @(posedge clock); #1;
    checkOutput("held_reaccept", W'(busy), W'(1));
    @(negedge clock);
    load_ctrl = 0;
    waitPulse(1'b0, e, o);
    checkOutput("held_second_latency", W'(e), W'(2));
    checkOutput("held_second_data", load_data, pat_2);
    @(posedge clock); #1;

    // Reset in the middle of RD_WAIT
    @(negedge clock);
    load_ctrl = 1; load_addr = 16'h0005;
    @(posedge clock); #1;
    checkOutput("rst_mid_busy_before", W'(busy), W'(1));
    @(negedge clock);
    reset = 0; load_ctrl = 0;
    #1;
    checkOutput("rst_mid_flags", W'({busy, load_valid, write_done, req_err}), W'(0));
    checkOutput("rst_mid_load_data", load_data, '0);
    @(negedge clock);
    reset = 1;
    seen = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (load_valid || busy) seen++;
    end
    checkOutput("rst_mid_no_valid_after", W'(seen), W'(0));

    // Reset in WR_WAIT before the commit edge: old contents survive
    doWrite(16'h0020, pat_e, "abort_pre");
    @(negedge clock);
    write_ctrl = 1; write_addr = 16'h0020; write_data = pat_f;
    @(posedge clock); #1;
    @(negedge clock);
    reset = 0; write_ctrl = 0;
    #1;
    checkOutput("abort_no_done", W'({write_done, busy}), W'(0));
    @(negedge clock);
    reset = 1;
    doLoad(16'h0020, pat_e, "abort_readback");

`ifdef VMEM_PARITY_EN
    doWrite(16'h0007, pat_a, "par_w");
    doLoad(16'h0007, pat_a, "par_clean");
    checkOutput("par_clean_err", W'(parity_err), W'(0));
    dut.mem[7][3*BITS] = ~dut.mem[7][3*BITS];
    doLoad(16'h0007, pat_a ^ (W'(1) << (3*BITS)), "par_flip");
    checkOutput("par_flip_err", W'(parity_err), W'(32'h0000_0008));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
